camera_capture: RTL and testbench

Pixel-clock-domain capture stage for the OV5640/OV7725 DVP output; it sits directly downstream of camera initialisation. It waits for the sensor configuration to finish, then discards a programmable number of settling frames. It packs byte pairs into RGB565 pixels, with pixel coordinates, frame markers and geometry-error flags, for the frame buffer writer.

---
 rtl/camera_pkg.sv | 19 +
 rtl/cdc_sync_bit.sv | 25 ++
 rtl/camera_capture.sv | 189 ++++++++++++++++++
 tb/tb_camera_capture.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/camera_pkg.sv
// Shared types and constants for the DVP camera capture stage.
package camera_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SKIP    = 2'd1,
        WAIT_VS = 2'd2,
        ACTIVE  = 2'd3
    } state_e;

    localparam int COORD_W         = 12;
    localparam int PIX_W           = 16;
    localparam bit HIGH_BYTE_FIRST = 1'b1;

    function automatic logic [COORD_W-1:0] sat_inc(input logic [COORD_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/cdc_sync_bit.sv
// Two-flop synchroniser for a single quasi-static level, resets to 0.
module cdc_sync_bit (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // NOTE: sequential state always uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/camera_capture.sv
// DVP capture: waits for sensor init, drops settling frames, then packs
// byte pairs into RGB565 pixels with coordinates, frame markers and error flags.
module camera_capture
    import camera_pkg::*;
#(
    parameter int IMAGE_WIDTH  = 800,
    parameter int IMAGE_HEIGHT = 480,
    parameter int SKIP_FRAMES  = 10
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic               Init_Done,
    input  logic               dvp_vsync,
    input  logic               dvp_href,
    input  logic [7:0]         dvp_data,
    output logic               DataValid,
    output logic [PIX_W-1:0]   DataPixel,
    output logic [COORD_W-1:0] pix_x,
    output logic [COORD_W-1:0] pix_y,
    output logic               Frame_Start,
    output logic               Frame_Done,
    output logic               line_err,
    output logic               frame_err
);

    localparam logic [COORD_W-1:0] WIDTH_C   = COORD_W'(IMAGE_WIDTH);
    localparam logic [COORD_W-1:0] HEIGHT_C  = COORD_W'(IMAGE_HEIGHT);
    localparam logic [15:0]        SKIP_LAST = 16'(SKIP_FRAMES - 1);

    logic init_s;
    logic vs_q, vs_dq, hs_q, hs_dq;
    logic [7:0] d_q;

    state_e state_q, state_d;
    logic [15:0]        skip_cnt_q, skip_cnt_d;
    logic               phase_q, phase_d;
    logic [7:0]         high_q, high_d;
    logic [COORD_W-1:0] x_cnt_q, x_cnt_d;
    logic [COORD_W-1:0] row_q, row_d;
    logic               in_line_q, in_line_d;
    logic               valid_q, valid_d;
    logic [PIX_W-1:0]   pixel_q, pixel_d;
    logic [COORD_W-1:0] pix_x_q, pix_x_d;
    logic               fs_q, fs_d, fd_q, fd_d;
    logic               line_err_q, line_err_d;
    logic               frame_err_q, frame_err_d;

    cdc_sync_bit u_init_sync (
        .clk_i (Clk),
        .rst_i (Rst),
        .d_i   (Init_Done),
        .q_o   (init_s)
    );

    wire vs_rise = vs_q & ~vs_dq;
    wire vs_fall = ~vs_q & vs_dq;
    wire hs_rise = hs_q & ~hs_dq;
    wire hs_fall = ~hs_q & hs_dq;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (init_s) state_d = (SKIP_FRAMES > 0) ? SKIP : WAIT_VS;
            SKIP:    if (vs_rise && skip_cnt_q == SKIP_LAST) state_d = WAIT_VS;
            WAIT_VS: if (vs_fall) state_d = ACTIVE;
            ACTIVE:  if (vs_rise) state_d = WAIT_VS;
            default: state_d = IDLE;
        endcase
        if (!init_s) state_d = IDLE;
    end

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        skip_cnt_d  = '0;
        phase_d     = phase_q;
        high_d      = high_q;
        x_cnt_d     = x_cnt_q;
        row_d       = row_q;
        in_line_d   = in_line_q;
        valid_d     = 1'b0;
        pixel_d     = pixel_q;
        pix_x_d     = pix_x_q;
        fs_d        = 1'b0;
        fd_d        = 1'b0;
        line_err_d  = line_err_q;
        frame_err_d = frame_err_q;

        if (state_q == SKIP) skip_cnt_d = vs_rise ? skip_cnt_q + 16'd1 : skip_cnt_q;

        if (state_q == WAIT_VS && state_d == ACTIVE) begin
            fs_d       = 1'b1;
            row_d      = '0;
            line_err_d = 1'b0;
            in_line_d  = 1'b0;
            phase_d    = 1'b0;
            x_cnt_d    = '0;
        end

        if (state_q == ACTIVE) begin
            // Line check precedes the frame check so a coincident href fall is counted.
            if (hs_fall && in_line_q) begin
                if (phase_q || x_cnt_q != WIDTH_C) line_err_d = 1'b1;
                row_d     = sat_inc(row_q);
                in_line_d = 1'b0;
            end else if (vs_rise && in_line_q && hs_q) begin
                line_err_d = 1'b1;
            end

            if (vs_rise && state_d == WAIT_VS) begin
                fd_d        = 1'b1;
                frame_err_d = (row_d != HEIGHT_C);
            end

            if (state_d == ACTIVE && hs_q && (hs_rise || in_line_q)) begin
                in_line_d = 1'b1;
                if (hs_rise || !phase_q) begin
                    high_d  = d_q;
                    phase_d = 1'b1;
                    if (hs_rise) x_cnt_d = '0;
                end else begin
                    valid_d = 1'b1;
                    pixel_d = HIGH_BYTE_FIRST ? {high_q, d_q} : {d_q, high_q};
                    pix_x_d = x_cnt_q;
                    x_cnt_d = sat_inc(x_cnt_q);
                    phase_d = 1'b0;
                end
            end
        end

        if (state_d != ACTIVE) in_line_d = 1'b0;
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            vs_q        <= 1'b0;
            vs_dq       <= 1'b0;
            hs_q        <= 1'b0;
            hs_dq       <= 1'b0;
            d_q         <= '0;
            skip_cnt_q  <= '0;
            phase_q     <= 1'b0;
            high_q      <= '0;
            x_cnt_q     <= '0;
            row_q       <= '0;
            in_line_q   <= 1'b0;
            valid_q     <= 1'b0;
            pixel_q     <= '0;
            pix_x_q     <= '0;
            fs_q        <= 1'b0;
            fd_q        <= 1'b0;
            line_err_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            vs_q        <= dvp_vsync;
            vs_dq       <= vs_q;
            hs_q        <= dvp_href;
            hs_dq       <= hs_q;
            d_q         <= dvp_data;
            skip_cnt_q  <= skip_cnt_d;
            phase_q     <= phase_d;
            high_q      <= high_d;
            x_cnt_q     <= x_cnt_d;
            row_q       <= row_d;
            in_line_q   <= in_line_d;
            valid_q     <= valid_d;
            pixel_q     <= pixel_d;
            pix_x_q     <= pix_x_d;
            fs_q        <= fs_d;
            fd_q        <= fd_d;
            line_err_q  <= line_err_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign DataValid   = valid_q;
    assign DataPixel   = pixel_q;
    assign pix_x       = pix_x_q;
    assign pix_y       = row_q;
    assign Frame_Start = fs_q;
    assign Frame_Done  = fd_q;
    assign line_err    = line_err_q;
    assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_camera_capture.sv
// Directed bench for camera_capture: scoreboarded pixels plus frame/error checks,
// with a second instance built for SKIP_FRAMES = 0.
module tb_camera_capture;

    typedef struct packed {
        logic [15:0] pix;
        logic [11:0] x;
        logic [11:0] y;
    } exp_t;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        Init_Done, Init_Done0;
    logic        dvp_vsync, dvp_href;
    logic [7:0]  dvp_data;

    logic        DataValid, Frame_Start, Frame_Done, line_err, frame_err;
    logic [15:0] DataPixel;
    logic [11:0] pix_x, pix_y;

    logic        DataValid0, Frame_Start0, Frame_Done0, line_err0, frame_err0;
    logic [15:0] DataPixel0;
    logic [11:0] pix_x0, pix_y0;

    int   checks = 0;
    int   failures = 0;
    int   dv_cnt = 0, fs_cnt = 0, fd_cnt = 0;
    int   dv0_cnt = 0, fs0_cnt = 0, fd0_cnt = 0;
    exp_t sb_q[$];
    logic [7:0] byte_val = 8'd1;

    always #5 Clk = ~Clk;

    camera_capture #(.IMAGE_WIDTH(4), .IMAGE_HEIGHT(3), .SKIP_FRAMES(2)) dut (
        .Clk(Clk), .Rst(Rst), .Init_Done(Init_Done),
        .dvp_vsync(dvp_vsync), .dvp_href(dvp_href), .dvp_data(dvp_data),
        .DataValid(DataValid), .DataPixel(DataPixel), .pix_x(pix_x), .pix_y(pix_y),
        .Frame_Start(Frame_Start), .Frame_Done(Frame_Done),
        .line_err(line_err), .frame_err(frame_err)
    );

    camera_capture #(.IMAGE_WIDTH(4), .IMAGE_HEIGHT(3), .SKIP_FRAMES(0)) dut0 (
        .Clk(Clk), .Rst(Rst), .Init_Done(Init_Done0),
        .dvp_vsync(dvp_vsync), .dvp_href(dvp_href), .dvp_data(dvp_data),
        .DataValid(DataValid0), .DataPixel(DataPixel0), .pix_x(pix_x0), .pix_y(pix_y0),
        .Frame_Start(Frame_Start0), .Frame_Done(Frame_Done0),
        .line_err(line_err0), .frame_err(frame_err0)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Monitor: outputs sampled on the falling edge, pixels popped from the scoreboard.
    always @(negedge Clk) begin
        if (DataValid) begin
            logic have;
            exp_t e;
            dv_cnt++;
            have = (sb_q.size() != 0);
            check("sb_have_expect", have, 1);
            if (have) begin
                e = sb_q.pop_front();
                check("sb_pixel_xy", {DataPixel, pix_x, pix_y}, e);
            end
        end
        if (Frame_Start)  fs_cnt++;
        if (Frame_Done)   fd_cnt++;
        if (DataValid0)   dv0_cnt++;
        if (Frame_Start0) fs0_cnt++;
        if (Frame_Done0)  fd0_cnt++;
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic send_line(input int nbytes, input bit cap, input int y);
        logic [7:0] prev = 8'd0;
        exp_t e;
        dvp_href = 1'b1;
        for (int i = 0; i < nbytes; i++) begin
            dvp_data = byte_val;
            if (cap && (i % 2 == 1)) begin
                e.pix = {prev, byte_val};
                e.x   = 12'(i / 2);
                e.y   = 12'(y);
                sb_q.push_back(e);
            end
            prev = byte_val;
            byte_val++;
            tick();
        end
        dvp_href = 1'b0;
        dvp_data = 8'd0;
        repeat (3) tick();
    endtask

    task automatic send_frame(input int nlines, input int l0, input int l1, input int l2,
                              input bit cap, input bit exp_fe, input bit exp_le, input string tag);
        int len;
        dvp_vsync = 1'b0;
        tick();
        tick();
        if (cap) begin
            check({tag, "_frame_start"}, Frame_Start, 1);
            check({tag, "_start_pix_y"}, pix_y, 0);
            check({tag, "_start_line_err"}, line_err, 0);
        end
        tick();
        for (int i = 0; i < nlines; i++) begin
            len = (i == 0) ? l0 : (i == 1) ? l1 : l2;
            send_line(len, cap, i);
        end
        dvp_vsync = 1'b1;
        tick();
        tick();
        if (cap) begin
            check({tag, "_frame_done"}, Frame_Done, 1);
            check({tag, "_frame_err"}, frame_err, exp_fe);
            check({tag, "_line_err"}, line_err, exp_le);
        end
        repeat (4) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, f0, e0, mark;

        Rst = 1'b1; Init_Done = 1'b0; Init_Done0 = 1'b0;
        dvp_vsync = 1'b1; dvp_href = 1'b0; dvp_data = 8'd0;
        repeat (3) tick();
        check("rst_valid", DataValid, 0);
        check("rst_pixel", DataPixel, 0);
        check("rst_pix_x", pix_x, 0);
        check("rst_pix_y", pix_y, 0);
        check("rst_frame_start", Frame_Start, 0);
        check("rst_frame_done", Frame_Done, 0);
        check("rst_line_err", line_err, 0);
        check("rst_frame_err", frame_err, 0);
        Rst = 1'b0;
        repeat (2) tick();
        Init_Done = 1'b1;
        repeat (5) tick();

        // Nominal: two skipped frames, then a captured 4x3 frame starting at byte 0x01.
        d0 = dv_cnt;
        send_frame(3, 8, 8, 8, 1'b0, 1'b0, 1'b0, "skip1");
        send_frame(3, 8, 8, 8, 1'b0, 1'b0, 1'b0, "skip2");
        check("skip_no_valid", dv_cnt - d0, 0);
        byte_val = 8'd1;
        d0 = dv_cnt; f0 = fs_cnt; e0 = fd_cnt;
        send_frame(3, 8, 8, 8, 1'b1, 1'b0, 1'b0, "nominal");
        check("nominal_pixels", dv_cnt - d0, 12);
        check("nominal_fs_count", fs_cnt - f0, 1);
        check("nominal_fd_count", fd_cnt - e0, 1);
        check("nominal_sb_empty", sb_q.size(), 0);

        // Odd-byte line: 7 bytes yield 3 pixels and a sticky line error.
        d0 = dv_cnt;
        send_frame(3, 7, 8, 8, 1'b1, 1'b0, 1'b1, "odd");
        check("odd_pixels", dv_cnt - d0, 11);
        send_frame(3, 8, 8, 8, 1'b1, 1'b0, 1'b0, "after_odd");

        // Short frame: two lines only.
        send_frame(2, 8, 8, 8, 1'b1, 1'b1, 1'b0, "short");
        send_frame(3, 8, 8, 8, 1'b1, 1'b0, 1'b0, "after_short");

        // Init_Done dropped mid-line.
        f0 = fs_cnt; e0 = fd_cnt;
        dvp_vsync = 1'b0;
        repeat (3) tick();
        send_line(8, 1'b1, 0);
        dvp_href = 1'b1;
        for (int i = 0; i < 4; i++) begin
            dvp_data = byte_val;
            if (i % 2 == 1) sb_q.push_back('{pix: {byte_val - 8'd1, byte_val}, x: 12'(i / 2), y: 12'd1});
            byte_val++;
            tick();
        end
        Init_Done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            dvp_data = byte_val;
            byte_val++;
            tick();
            if (i == 2) begin
                mark = dv_cnt;
                check("drop_valid_low", DataValid, 0);
            end
        end
        dvp_href = 1'b0;
        repeat (3) tick();
        send_line(8, 1'b0, 2);
        dvp_vsync = 1'b1;
        repeat (6) tick();
        check("drop_no_more_valid", dv_cnt - mark, 0);
        check("drop_no_frame_done", fd_cnt - e0, 0);
        check("drop_frame_started", fs_cnt - f0, 1);
        check("drop_sb_empty", sb_q.size(), 0);

        // Re-assert: SKIP_FRAMES frames are dropped again.
        Init_Done = 1'b1;
        repeat (5) tick();
        d0 = dv_cnt;
        send_frame(3, 8, 8, 8, 1'b0, 1'b0, 1'b0, "reskip1");
        send_frame(3, 8, 8, 8, 1'b0, 1'b0, 1'b0, "reskip2");
        check("reskip_no_valid", dv_cnt - d0, 0);
        d0 = dv_cnt;
        send_frame(3, 8, 8, 8, 1'b1, 1'b0, 1'b0, "recapture");
        check("recapture_pixels", dv_cnt - d0, 12);

        // Rst pulsed mid-frame.
        dvp_vsync = 1'b0;
        repeat (3) tick();
        send_line(8, 1'b1, 0);
        check("pre_rst_pix_y", pix_y, 1);
        Rst = 1'b1;
        #1;
        check("rst_mid_outputs",
              {DataValid, DataPixel, pix_x, pix_y, Frame_Start, Frame_Done, line_err, frame_err}, 0);
        tick();
        Rst = 1'b0;
        mark = dv_cnt;
        send_line(8, 1'b0, 1);
        send_line(8, 1'b0, 2);
        dvp_vsync = 1'b1;
        repeat (6) tick();
        check("rst_rest_no_valid", dv_cnt - mark, 0);

        // SKIP_FRAMES = 0 instance: init rises mid-frame, capture waits for next vsync fall.
        Init_Done = 1'b0;
        repeat (4) tick();
        mark = dv_cnt;
        dvp_vsync = 1'b0;
        repeat (3) tick();
        send_line(8, 1'b0, 0);
        Init_Done0 = 1'b1;
        d0 = dv0_cnt; f0 = fs0_cnt;
        send_line(8, 1'b0, 1);
        send_line(8, 1'b0, 2);
        dvp_vsync = 1'b1;
        repeat (6) tick();
        check("skip0_no_midframe_valid", dv0_cnt - d0, 0);
        check("skip0_no_midframe_start", fs0_cnt - f0, 0);
        d0 = dv0_cnt; f0 = fs0_cnt; e0 = fd0_cnt;
        send_frame(3, 8, 8, 8, 1'b0, 1'b0, 1'b0, "skip0");
        check("skip0_pixels", dv0_cnt - d0, 12);
        check("skip0_fs_count", fs0_cnt - f0, 1);
        check("skip0_fd_count", fd0_cnt - e0, 1);
        check("skip0_main_idle", dv_cnt - mark, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
